// File: rtl/sdr_16_rd_capture_if.sv
// Read-capture bus: READ tags and DQ in, packed FIFO words and status out.
interface sdr_16_rd_capture_if;
  logic        cmd_read;
  logic [15:0] dq_i;
  logic        fifo_full;
  logic        clr_i;
  logic        fifo_we;
  logic [31:0] fifo_wr_data;
  logic [1:0]  pending;
  logic        rd_idle;
  logic        overrun;
  logic        proto_err;

  modport master (
    output cmd_read, dq_i, fifo_full, clr_i,
    input  fifo_we, fifo_wr_data, pending,
    input  rd_idle, overrun, proto_err
  );

  modport slave (
    input  cmd_read, dq_i, fifo_full, clr_i,
    output fifo_we, fifo_wr_data, pending,
    output rd_idle, overrun, proto_err
  );
endinterface

// File: rtl/sdr_16_rd_capture.sv
// SDR16 read-data capture: packs two DQ beats into a FIFO word.
// SDR_RD_CAPTURE_INREG_EN adds an IOB input flop on DQ (+1 latency).
module sdr_16_rd_capture #(
  parameter int cl = 2
) (
  input logic                sdram_clk,
  input logic                sdram_rst_n,
  sdr_16_rd_capture_if.slave bus
);

`ifdef SDR_RD_CAPTURE_INREG_EN
  localparam int D = cl + 1;
  logic [15:0] dq_q;
  logic [15:0] dq_s;
  assign dq_s = dq_q;
  always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
    if (!sdram_rst_n) dq_q <= '0;
    else              dq_q <= bus.dq_i;
  end
`else
  localparam int D = cl;
  logic [15:0] dq_s;
  assign dq_s = bus.dq_i;
`endif

  logic [D-1:0] tag_q, tag_d;
  logic         beat0;
  logic         beat1_q, beat1_d;
  logic         wr_q, wr_d;
  logic [15:0]  hi_q, hi_d;
  logic [31:0]  data_q, data_d;
  logic [1:0]   pend_q, pend_d;
  logic         ovr_q, ovr_d;
  logic         perr_q, perr_d;
  logic         ov_set, pe_set;
  logic         inc_only, dec_only;

  assign beat0 = tag_q[D-1];
  assign inc_only = bus.cmd_read & ~wr_q;
  assign dec_only = wr_q & ~bus.cmd_read;

  always_comb begin
    tag_d   = {tag_q[D-2:0], bus.cmd_read};
    beat1_d = beat0;
    wr_d    = beat1_q;
    hi_d    = beat0 ? dq_s : hi_q;
    // A colliding beat0 still sees the old hi for the lo capture
    data_d  = beat1_q ? {hi_q, dq_s} : data_q;
    ov_set  = wr_q & bus.fifo_full;
    pe_set  = (bus.cmd_read & (pend_q == 2'd3))
            | (beat0 & beat1_q);
    pend_d  = pend_q;
    unique case (1'b1)
      inc_only: if (pend_q != 2'd3) pend_d = pend_q + 2'd1;
      dec_only: if (pend_q != 2'd0) pend_d = pend_q - 2'd1;
      default: ;
    endcase
    ovr_d  = ov_set | (ovr_q & ~bus.clr_i);
    perr_d = pe_set | (perr_q & ~bus.clr_i);
  end

  always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
    if (!sdram_rst_n) begin
      tag_q   <= '0;
      beat1_q <= 1'b0;
      wr_q    <= 1'b0;
      hi_q    <= '0;
      data_q  <= '0;
      pend_q  <= '0;
      ovr_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      tag_q   <= tag_d;
      beat1_q <= beat1_d;
      wr_q    <= wr_d;
      hi_q    <= hi_d;
      data_q  <= data_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      perr_q  <= perr_d;
    end
  end

  assign bus.fifo_we      = wr_q & ~bus.fifo_full;
  assign bus.fifo_wr_data = data_q;
  assign bus.pending      = pend_q;
  assign bus.overrun      = ovr_q;
  assign bus.proto_err    = perr_q;
  assign bus.rd_idle      = (pend_q == 2'd0) && (tag_q == '0)
                          && !beat1_q && !wr_q;

endmodule

// File: tb/tb_sdr_16_rd_capture.sv
// Bench for sdr_16_rd_capture: directed + random steps vs a
// cycle-history reference model.
module tb_sdr_16_rd_capture;
  localparam int CL = 2;
`ifdef SDR_RD_CAPTURE_INREG_EN
  localparam int OFF = 1;
`else
  localparam int OFF = 0;
`endif
  localparam int L = CL + 2 + OFF;
  localparam int N = 4096;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  sdr_16_rd_capture_if bus();

  sdr_16_rd_capture #(.cl(CL)) dut (
    .sdram_clk   (clk),
    .sdram_rst_n (rst_n),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  bit          cmd_h [N];
  logic [15:0] dq_h  [N];
  bit          full_h[N];
  int cyc = 0;
  int valid_from = 0;
  int n_eval = 0;
  int n_fail = 0;
  int pend = 0;
  bit ovr = 1'b0;
  bit perr = 1'b0;

  function automatic bit cmd_at(int i);
    if (i < valid_from || i < 0) return 1'b0;
    return cmd_h[i];
  endfunction

  task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
    n_eval++;
    assert (act === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d: observed %h expected %h",
             tag, cyc, act, exp);
    end
  endtask

  task automatic step(bit cmd, logic [15:0] dq, bit full,
                      bit clr, bit rst);
    bit wr, inc, idle, ov_set, pe_set;
    @(posedge clk);
    #1;
    inc = rst ? 1'b0 : cmd;
    bus.cmd_read  = inc;
    bus.dq_i      = dq;
    bus.fifo_full = full;
    bus.clr_i     = clr;
    cmd_h[cyc]  = inc;
    dq_h[cyc]   = dq;
    full_h[cyc] = full;
    if (rst) begin
      rst_n = 1'b0;
      pend = 0;
      ovr = 1'b0;
      perr = 1'b0;
      valid_from = cyc + 1;
    end
    @(negedge clk);
    wr = cmd_at(cyc - L);
    idle = (pend == 0);
    for (int k = 1; k <= L; k++)
      if (cmd_at(cyc - k)) idle = 1'b0;
    chk("fifo_we", 32'(bus.fifo_we), 32'(wr & !full));
    if (rst)
      chk("rst_data", bus.fifo_wr_data, 32'h0);
    else if (wr && !full)
      chk("wr_data", bus.fifo_wr_data,
          {dq_h[cyc - L + CL], dq_h[cyc - L + CL + 1]});
    chk("pending", 32'(bus.pending), 32'(pend));
    chk("rd_idle", 32'(bus.rd_idle), 32'(idle));
    chk("overrun", 32'(bus.overrun), 32'(ovr));
    chk("proto_err", 32'(bus.proto_err), 32'(perr));
    if (rst) begin
      rst_n = 1'b1;
    end else begin
      ov_set = wr & full;
      pe_set = (inc && pend == 3)
             || (cmd_at(cyc - CL - OFF) && cmd_at(cyc - CL - OFF - 1));
      if (inc && !wr && pend != 3) pend++;
      else if (wr && !inc && pend != 0) pend--;
      ovr  = ov_set | (ovr & !clr);
      perr = pe_set | (perr & !clr);
    end
    cyc++;
  endtask

  initial begin
    bus.cmd_read  = 1'b0;
    bus.dq_i      = '0;
    bus.fifo_full = 1'b0;
    bus.clr_i     = 1'b0;

    step(0, 16'h0, 0, 0, 1);
    step(0, 16'h0, 0, 0, 1);

    // single read
    for (int i = 0; i < L + 3; i++)
      step(i == 0,
           (i == CL) ? 16'hA5A5 :
           (i == CL + 1) ? 16'h3C3C : 16'($urandom),
           0, 0, 0);

    // streaming, one command every 2 cycles
    for (int i = 0; i < L + 10; i++)
      step(i < 8 && (i % 2) == 0, 16'(i + 1 - CL), 0, 0, 0);

    // overrun then clear
    for (int i = 0; i < L + 3; i++)
      step(i == 0, 16'($urandom), 1, 0, 0);
    step(0, 16'($urandom), 0, 1, 0);
    step(0, 16'($urandom), 0, 0, 0);

    // back-to-back commands: pending overflow and beat collision
    for (int i = 0; i < L + 6; i++)
      step(i < 4, 16'($urandom), 0, 0, 0);
    step(0, 16'($urandom), 0, 1, 0);
    step(0, 16'($urandom), 0, 0, 0);

    // random traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 2) == 0, 16'($urandom),
           $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, 0);
    for (int i = 0; i < L + 2; i++)
      step(0, 16'($urandom), 0, 1, 0);

    // reset in the middle of a burst
    step(1, 16'($urandom), 0, 0, 0);
    step(0, 16'($urandom), 0, 0, 0);
    step(0, 16'($urandom), 0, 0, 1);
    for (int i = 0; i < L + 4; i++)
      step(0, 16'($urandom), 0, 0, 0);

    // one more single read after reset
    for (int i = 0; i < L + 3; i++)
      step(i == 0, 16'($urandom), 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_eval, n_fail);
    $finish;
  end
endmodule
